// File: rtl/dense_pkg.sv
// Shared state encoding, status layout and saturation helpers for the dense layer engine.
package dense_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RD_X     = 4'd1,
    S_WT_X     = 4'd2,
    S_RD_W     = 4'd3,
    S_WT_W     = 4'd4,
    S_MAC      = 4'd5,
    S_NEXT_IN  = 4'd6,
    S_WR_Y     = 4'd7,
    S_NEXT_OUT = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  localparam int ST_STATE_LSB = 0;
  localparam int ST_IN_LSB    = 4;
  localparam int ST_OUT_LSB   = 16;

  // {above max, below min} of a w-bit signed range
  function automatic logic [1:0] clip_flags(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return {v > hi, v < lo};
  endfunction

  function automatic logic signed [63:0] shift_right(input logic signed [63:0] v, input int sh);
    return v >>> sh;
  endfunction

  function automatic logic [31:0] pack_status(input logic [15:0] o, input logic [11:0] i,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    r[ST_OUT_LSB +: 16]  = o;
    r[ST_IN_LSB +: 12]   = i;
    r[ST_STATE_LSB +: 4] = s;
    return r;
  endfunction

endpackage

// File: rtl/dense_mac_sat.sv
// Saturating accumulate and output quantiser (shift, clamp to DATA_W, optional ReLU).
module dense_mac_sat
  import dense_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 32,
  parameter int FRAC_SHIFT = 0,
  parameter int RELU       = 0
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] w,
  output logic signed [ACC_W-1:0]  acc_sum,
  output logic signed [DATA_W-1:0] q
);

  localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] Q_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] Q_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [63:0]        sum_wide, shifted;
  logic [1:0]                sum_clip, q_clip;
  logic signed [DATA_W-1:0]  q_sat;

  always_comb begin
    sum_wide = 64'(acc) + 64'(w);
    sum_clip = clip_flags(sum_wide, ACC_W);
    if (sum_clip[1])      acc_sum = ACC_MAX;
    else if (sum_clip[0]) acc_sum = ACC_MIN;
    else                  acc_sum = sum_wide[ACC_W-1:0];

    shifted = shift_right(64'(acc), FRAC_SHIFT);
    q_clip  = clip_flags(shifted, DATA_W);
    if (q_clip[1])      q_sat = Q_MAX;
    else if (q_clip[0]) q_sat = Q_MIN;
    else                q_sat = shifted[DATA_W-1:0];

    q = (RELU != 0 && q_sat[DATA_W-1]) ? '0 : q_sat;
  end

endmodule

// File: rtl/dense_layer_engine.sv
// Avalon-MM master computing one zero-skipping fully connected layer out of SDRAM.
//
// state    | meaning
// IDLE     | waiting for start
// RD_X     | read of x[in_idx] on the bus
// WT_X     | waiting for x data, zero x skips the weight
// RD_W     | read of w[out_idx][in_idx] on the bus
// WT_W     | waiting for weight data
// MAC      | saturating accumulate of the weight
// NEXT_IN  | advance input or start output write
// WR_Y     | write of quantised y[out_idx]
// NEXT_OUT | advance output node or finish
// DONE     | done held until start drops
module dense_layer_engine
  import dense_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int ACC_W      = 32,
  parameter int N_IN       = 784,
  parameter int N_OUT      = 200,
  parameter int X_BASE     = 600000,
  parameter int W_BASE     = 800,
  parameter int Y_BASE     = 400000,
  parameter int FRAC_SHIFT = 0,
  parameter int RELU       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  waitrequest,
  input  logic                  readdatavalid,
  input  logic [DATA_W-1:0]     readdata,
  output logic                  chipselect,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  read_n,
  output logic                  write_n,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W-1:0]     writedata,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  output logic [31:0]           status
);

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] X0       = ADDR_W'(X_BASE);
  localparam logic [ADDR_W-1:0] W0       = ADDR_W'(W_BASE);
  localparam logic [ADDR_W-1:0] Y0       = ADDR_W'(Y_BASE);
  localparam logic [15:0]       LAST_IN  = 16'(N_IN - 1);
  localparam logic [15:0]       LAST_OUT = 16'(N_OUT - 1);

  state_t                    state, state_nx;
  logic                      read_n_nx, write_n_nx, done_nx;
  logic [ADDR_W-1:0]         address_nx, x_ptr, x_ptr_nx, w_ptr, w_ptr_nx, y_ptr, y_ptr_nx;
  logic [DATA_W-1:0]         writedata_nx, w_reg, w_reg_nx;
  logic signed [ACC_W-1:0]   acc, acc_nx, acc_sum;
  logic signed [DATA_W-1:0]  q;
  logic [15:0]               in_idx, in_idx_nx, out_idx, out_idx_nx;

  dense_mac_sat #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_SHIFT(FRAC_SHIFT), .RELU(RELU)
  ) u_mac (
    .acc(acc), .w(w_reg), .acc_sum(acc_sum), .q(q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      read_n    <= 1'b1;
      write_n   <= 1'b1;
      address   <= '0;
      writedata <= '0;
      done      <= 1'b0;
      acc       <= '0;
      in_idx    <= '0;
      out_idx   <= '0;
      x_ptr     <= '0;
      w_ptr     <= '0;
      y_ptr     <= '0;
      w_reg     <= '0;
    end else begin
      state     <= state_nx;
      read_n    <= read_n_nx;
      write_n   <= write_n_nx;
      address   <= address_nx;
      writedata <= writedata_nx;
      done      <= done_nx;
      acc       <= acc_nx;
      in_idx    <= in_idx_nx;
      out_idx   <= out_idx_nx;
      x_ptr     <= x_ptr_nx;
      w_ptr     <= w_ptr_nx;
      y_ptr     <= y_ptr_nx;
      w_reg     <= w_reg_nx;
    end
  end

  // Bus strobes are set on the transition into a bus state so every output is a flop.
  always_comb begin
    state_nx     = state;
    read_n_nx    = read_n;
    write_n_nx   = write_n;
    address_nx   = address;
    writedata_nx = writedata;
    done_nx      = done;
    acc_nx       = acc;
    in_idx_nx    = in_idx;
    out_idx_nx   = out_idx;
    x_ptr_nx     = x_ptr;
    w_ptr_nx     = w_ptr;
    y_ptr_nx     = y_ptr;
    w_reg_nx     = w_reg;
    unique case (state)
      S_IDLE: if (start) begin
        in_idx_nx  = '0;
        out_idx_nx = '0;
        acc_nx     = '0;
        x_ptr_nx   = X0;
        w_ptr_nx   = W0;
        y_ptr_nx   = Y0;
        read_n_nx  = 1'b0;
        address_nx = X0;
        state_nx   = S_RD_X;
      end
      S_RD_X, S_RD_W: if (!waitrequest) begin
        read_n_nx = 1'b1;
        state_nx  = (state == S_RD_X) ? S_WT_X : S_WT_W;
      end
      S_WT_X: if (readdatavalid) begin
        if (readdata != '0) begin
          read_n_nx  = 1'b0;
          address_nx = w_ptr;
          state_nx   = S_RD_W;
        end else begin
          w_ptr_nx = w_ptr + STEP;
          state_nx = S_NEXT_IN;
        end
      end
      S_WT_W: if (readdatavalid) begin
        w_reg_nx = readdata;
        state_nx = S_MAC;
      end
      S_MAC: begin
        acc_nx   = acc_sum;
        w_ptr_nx = w_ptr + STEP;
        state_nx = S_NEXT_IN;
      end
      S_NEXT_IN: if (in_idx == LAST_IN) begin
        write_n_nx   = 1'b0;
        address_nx   = y_ptr;
        writedata_nx = q;
        state_nx     = S_WR_Y;
      end else begin
        in_idx_nx  = in_idx + 16'd1;
        x_ptr_nx   = x_ptr + STEP;
        read_n_nx  = 1'b0;
        address_nx = x_ptr + STEP;
        state_nx   = S_RD_X;
      end
      S_WR_Y: if (!waitrequest) begin
        write_n_nx = 1'b1;
        y_ptr_nx   = y_ptr + STEP;
        state_nx   = S_NEXT_OUT;
      end
      S_NEXT_OUT: begin
        acc_nx    = '0;
        in_idx_nx = '0;
        x_ptr_nx  = X0;
        if (out_idx == LAST_OUT) begin
          done_nx  = 1'b1;
          state_nx = S_DONE;
        end else begin
          out_idx_nx = out_idx + 16'd1;
          read_n_nx  = 1'b0;
          address_nx = X0;
          state_nx   = S_RD_X;
        end
      end
      S_DONE: if (!start) begin
        done_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign chipselect = 1'b1;
  assign byteenable = '1;
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign status     = pack_status(out_idx, in_idx[11:0], state);

endmodule

// File: tb/tb_dense_layer_engine.sv
// Bench for dense_layer_engine: three parameterisations share one SDRAM model and scoreboard.
module tb_dense_layer_engine;

  localparam int XB = 600000;
  localparam int WB = 800;
  localparam int YB = 400000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        waitrequest = 1'b0;
  logic        readdatavalid = 1'b0;
  logic [15:0] readdata = '0;

  logic        start_a [3];
  logic        cs_a [3], rd_n_a [3], wr_n_a [3], done_a [3], busy_a [3];
  logic [1:0]  be_a [3];
  logic [31:0] addr_a [3], st_a [3];
  logic [15:0] wd_a [3];

  always #5 clk = ~clk;

  // 0: 4x2 basic, 1: 4x2 narrow accumulator with ReLU, 2: 3x200 default bases
  dense_layer_engine #(.N_IN(4), .N_OUT(2)) u_a (
    .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .chipselect(cs_a[0]), .byteenable(be_a[0]), .read_n(rd_n_a[0]),
    .write_n(wr_n_a[0]), .address(addr_a[0]), .writedata(wd_a[0]), .start(start_a[0]),
    .done(done_a[0]), .busy(busy_a[0]), .status(st_a[0]));

  dense_layer_engine #(.N_IN(4), .N_OUT(2), .ACC_W(17), .RELU(1)) u_b (
    .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .chipselect(cs_a[1]), .byteenable(be_a[1]), .read_n(rd_n_a[1]),
    .write_n(wr_n_a[1]), .address(addr_a[1]), .writedata(wd_a[1]), .start(start_a[1]),
    .done(done_a[1]), .busy(busy_a[1]), .status(st_a[1]));

  dense_layer_engine #(.N_IN(3), .N_OUT(200)) u_c (
    .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .chipselect(cs_a[2]), .byteenable(be_a[2]), .read_n(rd_n_a[2]),
    .write_n(wr_n_a[2]), .address(addr_a[2]), .writedata(wd_a[2]), .start(start_a[2]),
    .done(done_a[2]), .busy(busy_a[2]), .status(st_a[2]));

  int          checks = 0;
  int          failures = 0;
  int          sel = 0;
  bit          stall_en = 0, hold_wr = 0, pending = 0;
  int          pend_cnt = 0;
  logic [15:0] pend_data = '0;
  bit          prev_rd_stall = 0, prev_wr_stall = 0;
  logic [31:0] prev_addr = '0, last_wa = '0;
  logic [15:0] prev_wd = '0;
  int          wreads = 0, nwrites = 0;
  logic [15:0] mem [int];
  int          exp_rd [$];
  int          exp_wa [$];
  logic [15:0] exp_wd [$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  function automatic longint clampv(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Expected bus traffic: every x in order, a weight only behind a non-zero x, then y.
  task automatic build_model(input int n_in, input int n_out, input int acc_w, input int relu);
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    for (int j = 0; j < n_out; j++) begin
      longint acc, q;
      acc = 0;
      for (int i = 0; i < n_in; i++) begin
        exp_rd.push_back(XB + 2 * i);
        if (mem_rd(XB + 2 * i) != 16'h0) begin
          exp_rd.push_back(WB + 2 * (j * n_in + i));
          acc = clampv(acc + longint'($signed(mem_rd(WB + 2 * (j * n_in + i)))), acc_w);
        end
      end
      q = clampv(acc, 16);
      if (relu != 0 && q < 0) q = 0;
      exp_wa.push_back(YB + 2 * j);
      exp_wd.push_back(16'(q));
    end
  endtask

  // One cycle of SDRAM slave plus the per-cycle bus scoreboard.
  task automatic tick();
    logic rdn, wrn;
    logic [31:0] ad;
    logic [15:0] wd;
    @(negedge clk);
    rdn = rd_n_a[sel];
    wrn = wr_n_a[sel];
    ad  = addr_a[sel];
    wd  = wd_a[sel];
    if (reset_n && prev_rd_stall) begin
      check("rd_hold_rd_n", rdn, 0);
      check("rd_hold_addr", ad, prev_addr);
    end
    if (reset_n && prev_wr_stall) begin
      check("wr_hold_wr_n", wrn, 0);
      check("wr_hold_addr", ad, prev_addr);
      check("wr_hold_data", wd, prev_wd);
    end
    readdatavalid = 1'b0;
    if (pending) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        readdatavalid = 1'b1;
        readdata      = pend_data;
        pending       = 0;
      end
    end else if (stall_en && $urandom_range(0, 4) == 0) begin
      readdatavalid = 1'b1;
      readdata      = 16'h5A5A;
    end
    waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    if (hold_wr && !wrn) waitrequest = 1'b1;
    if (!reset_n) begin
      pending       = 0;
      readdatavalid = 1'b0;
      prev_rd_stall = 0;
      prev_wr_stall = 0;
    end else begin
      if (!rdn && !waitrequest) begin
        check("one_outstanding", pending, 0);
        if (exp_rd.size() == 0) check("rd_unexpected", ad, -1);
        else check("rd_addr", ad, exp_rd.pop_front());
        if (ad < YB) wreads++;
        pending   = 1;
        pend_cnt  = stall_en ? int'($urandom_range(1, 5)) : 1;
        pend_data = mem_rd(int'(ad));
      end
      if (!wrn && !waitrequest) begin
        if (exp_wa.size() == 0) check("wr_unexpected", ad, -1);
        else begin
          check("wr_addr", ad, exp_wa.pop_front());
          check("wr_data", wd, exp_wd.pop_front());
        end
        mem[int'(ad)] = wd;
        nwrites++;
        last_wa = ad;
      end
      prev_rd_stall = !rdn && waitrequest;
      prev_wr_stall = !wrn && waitrequest;
      prev_addr     = ad;
      prev_wd       = wd;
    end
  endtask

  task automatic run_layer(input int s, input int n_in, input int n_out, input int acc_w,
                           input int relu, input bit drop_start, input bit hold_after);
    int cyc;
    build_model(n_in, n_out, acc_w, relu);
    sel = s;
    wreads = 0;
    nwrites = 0;
    start_a[s] = 1'b1;
    cyc = 0;
    while (!done_a[s] && cyc < 60000) begin
      tick();
      cyc++;
      if (drop_start && cyc == 12) start_a[s] = 1'b0;
    end
    check("done_seen", done_a[s], 1);
    check("status_out_idx", st_a[s][31:16], n_out - 1);
    check("status_state_done", st_a[s][3:0], 9);
    check("busy_at_done", busy_a[s], 0);
    check("reads_left", exp_rd.size(), 0);
    check("writes_left", exp_wa.size(), 0);
    if (hold_after) begin
      repeat (5) tick();
      check("done_held", done_a[s], 1);
    end
    start_a[s] = 1'b0;
    tick();
    check("done_cleared", done_a[s], 0);
    check("state_idle", st_a[s][3:0], 0);
  endtask

  task automatic load_t1();
    int r0 [4] = '{10, 20, -3, 7};
    int xv [4] = '{1, 0, 5, 0};
    for (int i = 0; i < 4; i++) begin
      mem[XB + 2 * i]     = 16'(xv[i]);
      mem[WB + 2 * i]     = 16'(r0[i]);
      mem[WB + 8 + 2 * i] = 16'hFFFF;
    end
    mem[YB]     = 16'hDEAD;
    mem[YB + 2] = 16'hDEAD;
  endtask

  task automatic load_t2();
    for (int i = 0; i < 4; i++) begin
      mem[XB + 2 * i]     = 16'd1;
      mem[WB + 2 * i]     = 16'h7FFF;
      mem[WB + 8 + 2 * i] = 16'h8000;
    end
    mem[YB]     = 16'hDEAD;
    mem[YB + 2] = 16'hDEAD;
  endtask

  task automatic load_t6();
    mem[XB]     = 16'd2;
    mem[XB + 2] = 16'd0;
    mem[XB + 4] = 16'hFFFF;
    for (int j = 0; j < 200; j++) begin
      for (int i = 0; i < 3; i++) mem[WB + 2 * (j * 3 + i)] = 16'(j * 37 + i * 11 - 300);
      mem[YB + 2 * j] = 16'hDEAD;
    end
  endtask

  initial begin
    int cyc;
    for (int s = 0; s < 3; s++) start_a[s] = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      check("rst_read_n", rd_n_a[s], 1);
      check("rst_write_n", wr_n_a[s], 1);
      check("rst_address", addr_a[s], 0);
      check("rst_writedata", wd_a[s], 0);
      check("rst_done", done_a[s], 0);
      check("rst_busy", busy_a[s], 0);
      check("rst_status", st_a[s], 0);
      check("chipselect", cs_a[s], 1);
      check("byteenable", be_a[s], 3);
    end
    reset_n = 1'b1;
    tick();

    // basic zero-skipping sum
    load_t1();
    run_layer(0, 4, 2, 32, 0, 0, 0);
    check("t1_y0", mem_rd(YB), 7);
    check("t1_y1", mem_rd(YB + 2), 16'hFFFE);
    check("t1_wreads", wreads, 4);

    // output and accumulator saturation, ReLU
    load_t2();
    run_layer(0, 4, 2, 32, 0, 0, 0);
    check("t2_y0_pos_sat", mem_rd(YB), 16'h7FFF);
    check("t2_y1_neg_sat", mem_rd(YB + 2), 16'h8000);
    load_t2();
    run_layer(1, 4, 2, 17, 1, 0, 0);
    check("t2_acc_sat_y0", mem_rd(YB), 16'h7FFF);
    check("t2_relu_y1", mem_rd(YB + 2), 0);

    // random stalls, read latency and stray readdatavalid
    load_t1();
    stall_en = 1;
    run_layer(0, 4, 2, 32, 0, 0, 0);
    stall_en = 0;
    check("t3_y0", mem_rd(YB), 7);
    check("t3_y1", mem_rd(YB + 2), 16'hFFFE);

    // reset while a write is stalled
    load_t1();
    build_model(4, 2, 32, 0);
    sel = 0;
    hold_wr = 1;
    start_a[0] = 1'b1;
    cyc = 0;
    while (st_a[0][3:0] != 4'd7 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("t4_reached_wr_y", st_a[0][3:0], 7);
    repeat (3) tick();
    check("t4_write_stalled", wr_n_a[0], 0);
    #2 reset_n = 1'b0;
    #1;
    check("t4_write_n_async", wr_n_a[0], 1);
    check("t4_read_n_async", rd_n_a[0], 1);
    check("t4_state_idle", st_a[0][3:0], 0);
    check("t4_done", done_a[0], 0);
    start_a[0] = 1'b0;
    hold_wr = 0;
    tick();
    reset_n = 1'b1;
    tick();
    check("t4_no_partial_write", mem_rd(YB), 16'hDEAD);
    load_t1();
    run_layer(0, 4, 2, 32, 0, 0, 0);
    check("t4_y0", mem_rd(YB), 7);
    check("t4_y1", mem_rd(YB + 2), 16'hFFFE);

    // start dropped mid-run, then start held past done, each a full rerun
    load_t1();
    run_layer(0, 4, 2, 32, 0, 1, 0);
    check("t5a_y1", mem_rd(YB + 2), 16'hFFFE);
    load_t1();
    run_layer(0, 4, 2, 32, 0, 0, 1);
    check("t5b_y0", mem_rd(YB), 7);

    // default bases, 200 output nodes
    load_t6();
    run_layer(2, 3, 200, 32, 0, 0, 0);
    check("t6_nwrites", nwrites, 200);
    check("t6_last_addr", last_wa, YB + 398);
    check("t6_y0", mem_rd(YB), 16'hFDBE);
    check("t6_y199", mem_rd(YB + 398), 14148);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
